// File: rtl/toff_cascade_seq.sv
// Toffoli cascade engine: applies up to DEPTH programmed gates to a WIDTH-bit word, one per clock,
// forward (dir=0) or reverse (dir=1). Optional TOFF_ROUNDTRIP_EN adds an undo pass and rt_err flag.
module toff_cascade_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [$clog2(WIDTH)-1:0]   prog_ctl_a,
  input  logic [$clog2(WIDTH)-1:0]   prog_ctl_b,
  input  logic [$clog2(WIDTH)-1:0]   prog_tgt,
  output logic                       prog_err,
  input  logic                       start,
  input  logic                       dir,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic [WIDTH-1:0]           din,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           dout
`ifdef TOFF_ROUNDTRIP_EN
  ,
  output logic                       rt_err
`endif
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int AW   = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef TOFF_ROUNDTRIP_EN
  localparam logic [1:0] S_BACK = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] st;
  logic [WIDTH-1:0] st_next;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_step;
  logic [AW:0]      rem;
  logic [AW:0]      eff_len;
  logic             dir_q;
  logic [DEPTH-1:0] vld;
  logic [IDXW-1:0]  tbl_a [DEPTH];
  logic [IDXW-1:0]  tbl_b [DEPTH];
  logic [IDXW-1:0]  tbl_t [DEPTH];
  logic             addr_ok;
  logic             wr_ok;
  logic             fire;
`ifdef TOFF_ROUNDTRIP_EN
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] res;
  logic [AW:0]      len_q;
`endif

  assign addr_ok = ({1'b0, prog_addr} < (AW+1)'(DEPTH));
  assign wr_ok   = addr_ok
                 && ({1'b0, prog_ctl_a} < (IDXW+1)'(WIDTH))
                 && ({1'b0, prog_ctl_b} < (IDXW+1)'(WIDTH))
                 && ({1'b0, prog_tgt}   < (IDXW+1)'(WIDTH))
                 && (prog_tgt != prog_ctl_a)
                 && (prog_tgt != prog_ctl_b);

  assign eff_len  = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign ptr_step = dir_q ? (ptr - 1'b1) : (ptr + 1'b1);

  // An invalid entry never fires, so it behaves as the identity gate.
  assign fire = vld[ptr] && st[tbl_a[ptr]] && st[tbl_b[ptr]];

  always_comb begin
    st_next = st;
    if (fire) st_next[tbl_t[ptr]] = ~st[tbl_t[ptr]];
  end

`ifdef TOFF_ROUNDTRIP_EN
  assign busy = (state == S_RUN) || (state == S_BACK);
`else
  assign busy = (state == S_RUN);
`endif

  // Gate payload needs no reset: the valid bits alone decide whether an entry acts.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE) && wr_ok) begin
      tbl_a[prog_addr] <= prog_ctl_a;
      tbl_b[prog_addr] <= prog_ctl_b;
      tbl_t[prog_addr] <= prog_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      st       <= '0;
      ptr      <= '0;
      rem      <= '0;
      dir_q    <= 1'b0;
      vld      <= '0;
      dout     <= '0;
      done     <= 1'b0;
      prog_err <= 1'b0;
`ifdef TOFF_ROUNDTRIP_EN
      din_q    <= '0;
      res      <= '0;
      len_q    <= '0;
      rt_err   <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      prog_err <= 1'b0;

      if (prog_we) begin
        if (state != S_IDLE) begin
          prog_err <= 1'b1;
        end else if (wr_ok) begin
          vld[prog_addr] <= 1'b1;
        end else begin
          prog_err <= 1'b1;
          if (addr_ok) vld[prog_addr] <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            st    <= din;
            dir_q <= dir;
            rem   <= eff_len;
            ptr   <= dir ? AW'(eff_len - 1'b1) : '0;
`ifdef TOFF_ROUNDTRIP_EN
            din_q  <= din;
            len_q  <= eff_len;
            rt_err <= 1'b0;
`endif
            if (eff_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              dout  <= din;
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          st <= st_next;
          if (rem == (AW+1)'(1)) begin
`ifdef TOFF_ROUNDTRIP_EN
            // ptr already sits on the last gate applied, which is the first one to undo.
            state <= S_BACK;
            res   <= st_next;
            rem   <= len_q;
            dir_q <= ~dir_q;
`else
            state <= S_DONE;
            done  <= 1'b1;
            dout  <= st_next;
`endif
          end else begin
            rem <= rem - 1'b1;
            ptr <= ptr_step;
          end
        end

`ifdef TOFF_ROUNDTRIP_EN
        S_BACK: begin
          st <= st_next;
          if (rem == (AW+1)'(1)) begin
            state  <= S_DONE;
            done   <= 1'b1;
            dout   <= res;
            rt_err <= (st_next != din_q);
          end else begin
            rem <= rem - 1'b1;
            ptr <= ptr_step;
          end
        end
`endif

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toff_cascade_seq.sv
// Bench for toff_cascade_seq: directed cases plus randomized traffic against a behavioural model.
module tb_toff_cascade_seq;

`ifdef TOFF_ROUNDTRIP_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [2:0] prog_ctl_a, prog_ctl_b, prog_tgt;
  logic       prog_err;
  logic       start, dir;
  logic [4:0] len;
  logic [7:0] din;
  logic       busy, done;
  logic [7:0] dout;
`ifdef TOFF_ROUNDTRIP_EN
  logic       rt_err;
`endif

  toff_cascade_seq #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_ctl_a(prog_ctl_a), .prog_ctl_b(prog_ctl_b), .prog_tgt(prog_tgt),
    .prog_err(prog_err),
    .start(start), .dir(dir), .len(len), .din(din),
    .busy(busy), .done(done), .dout(dout)
`ifdef TOFF_ROUNDTRIP_EN
    , .rt_err(rt_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: gate list as arrays, a run as a countdown to done.
  bit         mv [16];
  logic [2:0] ma [16], mb [16], mt [16];
  int         r;
  logic [7:0] e_dout, res_pend;
  logic       e_perr;
  wire        e_busy = (r > 1);
  wire        e_done = (r == 1);
`ifdef TOFF_ROUNDTRIP_EN
  logic       e_rt, rt_pend;
`endif

  function automatic int efl(input logic [4:0] l);
    return (l > 5'd16) ? 16 : int'(l);
  endfunction

  function automatic logic [7:0] apply(input logic [7:0] w0, input logic rev, input int n);
    logic [7:0] w = w0;
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = rev ? (n - 1 - i) : i;
      if (mv[idx] && w[ma[idx]] && w[mb[idx]]) w[mt[idx]] = ~w[mt[idx]];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= 0;
      e_dout   <= '0;
      res_pend <= '0;
      e_perr   <= 1'b0;
      for (int i = 0; i < 16; i++) mv[i] <= 1'b0;
`ifdef TOFF_ROUNDTRIP_EN
      e_rt    <= 1'b0;
      rt_pend <= 1'b0;
`endif
    end else begin
      e_perr <= prog_we && (r != 0 || prog_tgt == prog_ctl_a || prog_tgt == prog_ctl_b);
      if (prog_we && r == 0) begin
        mv[prog_addr] <= (prog_tgt != prog_ctl_a) && (prog_tgt != prog_ctl_b);
        ma[prog_addr] <= prog_ctl_a;
        mb[prog_addr] <= prog_ctl_b;
        mt[prog_addr] <= prog_tgt;
      end
      if (r > 0) begin
        r <= r - 1;
        if (r == 2) begin
          e_dout <= res_pend;
`ifdef TOFF_ROUNDTRIP_EN
          e_rt <= rt_pend;
`endif
        end
      end else if (start) begin
        r        <= efl(len) * K + 1;
        res_pend <= apply(din, dir, efl(len));
        if (efl(len) == 0) e_dout <= din;
`ifdef TOFF_ROUNDTRIP_EN
        e_rt    <= 1'b0;
        rt_pend <= (apply(apply(din, dir, efl(len)), !dir, efl(len)) != din);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("dout", dout, e_dout);
      chk("prog_err", prog_err, e_perr);
`ifdef TOFF_ROUNDTRIP_EN
      chk("rt_err", rt_err, e_rt);
`endif
    end
  end

  // Called right after a negedge; returns right after a negedge.
  task automatic prog(input logic [3:0] a_addr, input logic [2:0] a, b, t, input logic exp_err);
    prog_we = 1'b1; prog_addr = a_addr; prog_ctl_a = a; prog_ctl_b = b; prog_tgt = t;
    @(negedge clk);
    prog_we = 1'b0;
    chk("prog_err_pulse", prog_err, exp_err);
  endtask

  task automatic run(input logic [7:0] w, input logic d, input logic [4:0] l,
                     output int cyc, output logic [7:0] res);
    start = 1'b1; din = w; dir = d; len = l;
    cyc = 0;
    res = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = c;
        res = dout;
        break;
      end
    end
    if (cyc == 0) chk("run_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  int         cyc, ndone;
  logic [7:0] res;

  initial begin
    rst_n = 1'b0; prog_we = 0; prog_addr = 0; prog_ctl_a = 0; prog_ctl_b = 0; prog_tgt = 0;
    start = 0; dir = 0; len = 0; din = 0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_prog_err", prog_err, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    prog(4'd0, 3'd0, 3'd1, 3'd7, 1'b0);
    prog(4'd1, 3'd7, 3'd2, 3'd3, 1'b0);
    chk("model_pin_fwd", apply(8'h07, 1'b0, 2), 8'h8F);
    chk("model_pin_rev", apply(8'h8F, 1'b1, 2), 8'h07);

    run(8'h07, 1'b0, 5'd2, cyc, res);
    chk("t1_latency", cyc, 2 * K + 1);
    chk("t1_dout", res, 8'h8F);
    run(8'h8F, 1'b1, 5'd2, cyc, res);
    chk("t2_dout", res, 8'h07);

    prog(4'd0, 3'd4, 3'd5, 3'd4, 1'b1);
    run(8'h30, 1'b0, 5'd1, cyc, res);
    chk("t3_dout", res, 8'h30);
    chk("t3_latency", cyc, K + 1);
    run(8'h33, 1'b0, 5'd1, cyc, res);
    chk("t3_invalid_entry", res, 8'h33);

    run(8'hA5, 1'b0, 5'd0, cyc, res);
    chk("t4_len0_latency", cyc, 1);
    chk("t4_len0_dout", res, 8'hA5);

    prog(4'd5, 3'd3, 3'd3, 3'd6, 1'b0);
    start = 1'b1; din = 8'h5A; dir = 1'b0; len = 5'd16;
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == 4);
      if (c == 4) begin din = 8'hFF; dir = 1'b1; len = 5'd3; end
      if (done) begin cyc = c; res = dout; break; end
    end
    start = 1'b0;
    chk("t4_len16_latency", cyc, 16 * K + 1);
    chk("t4_len16_dout", res, apply(8'h5A, 1'b0, 16));
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_single_done", ndone, 0);

    start = 1'b1; din = 8'h0F; dir = 1'b0; len = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_dout", dout, 8'h00);
    chk("t5_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_no_done", ndone, 0);

    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom_range(0, 7) == 0);
      din        = 8'($urandom);
      dir        = 1'($urandom);
      len        = 5'($urandom_range(0, 19));
      prog_we    = !start && ($urandom_range(0, 3) == 0);
      prog_addr  = 4'($urandom);
      prog_ctl_a = 3'($urandom);
      prog_ctl_b = 3'($urandom);
      prog_tgt   = 3'($urandom);
      @(negedge clk);
    end
    start   = 1'b0;
    prog_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
